imem_responder: RTL

//  Instruction-side memory responder: the far end of the fetch port driven by the IF stage.

---
 rtl/imem_responder_pkg.sv | 14 +
 rtl/imem_responder_array.sv | 34 +++
 rtl/imem_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared state encoding and default sizing for the instruction memory responder
package imem_responder_pkg;

    localparam int IMEM_WORD_SIZE  = 16;
    localparam int IMEM_DEPTH_LOG2 = 8;
    localparam int IMEM_LATENCY    = 2;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_responder_array.sv
// imem_array: word storage with one registered read port (the responder's data output) and one write port
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int WORD_SIZE  = IMEM_WORD_SIZE,
    parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_rd_en,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [WORD_SIZE-1:0]  i_wdata,
    output logic [WORD_SIZE-1:0]  o_rdata
);

    // Storage is not reset; named mem so benches can preload it by hierarchy.
    logic [WORD_SIZE-1:0] mem [0:(2**DEPTH_LOG2)-1];
    logic [WORD_SIZE-1:0] r_rdata;

    // Runtime write port.
    always_ff @(posedge clk) begin
        if (i_wr_en) mem[i_addr] <= i_wdata;
    end

    // Registered read; the register holds its word until the next read or reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rdata <= '0;
        else if (i_rd_en) r_rdata <= mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder; IMEM_WRITE_EN enables runtime writes
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int WORD_SIZE  = IMEM_WORD_SIZE,
    parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2,
    parameter int LATENCY    = IMEM_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_readM,
    input  logic                 i_writeM,
    input  logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_wdata,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    output logic                 busy
);

    localparam int CW = $clog2(LATENCY + 1);

    imem_state_e           r_state;
    imem_state_e           w_next;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [CW-1:0]         r_count;
    logic                  r_ready;
    logic                  w_accept;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic [WORD_SIZE-1:0]  w_wr_data;
    logic                  w_unused;

`ifdef IMEM_WRITE_EN
    logic                  r_is_wr;
    logic [WORD_SIZE-1:0]  r_wdata;

    // Capture the direction and write data of an accepted request; a read wins over a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_wr <= 1'b0;
            r_wdata <= '0;
        end else if (r_state == IMEM_IDLE && w_accept) begin
            r_is_wr <= ~i_readM;
            r_wdata <= i_wdata;
        end
    end

    assign w_accept  = i_readM | i_writeM;
    assign w_rd_en   = (r_state == IMEM_RESP) && !r_is_wr;
    assign w_wr_en   = (r_state == IMEM_RESP) && r_is_wr;
    assign w_wr_data = r_wdata;
`else
    assign w_accept  = i_readM;
    assign w_rd_en   = (r_state == IMEM_RESP);
    assign w_wr_en   = 1'b0;
    assign w_wr_data = i_wdata;
`endif

    // Address bits above the array depth wrap away; i_writeM only matters with writes enabled.
    assign w_unused = ^{i_address, i_writeM};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IMEM_IDLE;
        else r_state <= w_next;
    end

    // Next state: accept only in IDLE, wait out the latency, then one RESP cycle.
    always_comb begin
        w_next = r_state;
        if (r_state == IMEM_IDLE && w_accept) w_next = (LATENCY > 1) ? IMEM_WAIT : IMEM_RESP;
        else if (r_state == IMEM_WAIT && r_count == CW'(1)) w_next = IMEM_RESP;
        else if (r_state == IMEM_RESP) w_next = IMEM_IDLE;
    end

    // Latch the address and load the latency counter on acceptance; the pulse is registered
    // on the edge leaving RESP so it lands exactly LATENCY edges after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= (r_state == IMEM_RESP);
            if (r_state == IMEM_IDLE && w_accept) begin
                r_addr  <= i_address[DEPTH_LOG2-1:0];
                r_count <= CW'(LATENCY - 1);
            end else if (r_state == IMEM_WAIT) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    imem_array #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk    (clk),
        .reset_n(reset_n),
        .i_rd_en(w_rd_en),
        .i_wr_en(w_wr_en),
        .i_addr (r_addr),
        .i_wdata(w_wr_data),
        .o_rdata(i_data)
    );

    assign i_ready = r_ready;
    assign busy    = (r_state != IMEM_IDLE);

endmodule
